// File: rtl/rv32i_types.sv
// Shared RV32 types for the execution units: mul/div op encodings, the
// mul/div FSM state enum and the reservation-station entry payload.
// No ports (package).
package rv32i_types;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ROB_IDX_W  = 5;

  // Encodings follow the RV32M funct3 field.
  typedef enum logic [2:0] {
    MOP_MUL    = 3'd0,
    MOP_MULH   = 3'd1,
    MOP_MULHSU = 3'd2,
    MOP_MULHU  = 3'd3,
    MOP_DIV    = 3'd4,
    MOP_DIVU   = 3'd5,
    MOP_REM    = 3'd6,
    MOP_REMU   = 3'd7
  } multop_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  typedef struct packed {
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    multop_t               multop;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [ROB_IDX_W-1:0]  rd_rob_idx;
    logic                  regf_we;
  } reservation_station_t;

  function automatic logic op_is_div(input multop_t op);
    return (op == MOP_DIV) || (op == MOP_DIVU) || (op == MOP_REM) || (op == MOP_REMU);
  endfunction

  function automatic logic op_is_rem(input multop_t op);
    return (op == MOP_REM) || (op == MOP_REMU);
  endfunction

  function automatic logic op_div_signed(input multop_t op);
    return (op == MOP_DIV) || (op == MOP_REM);
  endfunction

  // rs1 is signed for every multiply except MULHU.
  function automatic logic op_mul_a_signed(input multop_t op);
    return (op != MOP_MULHU);
  endfunction

  function automatic logic op_mul_b_signed(input multop_t op);
    return (op == MOP_MUL) || (op == MOP_MULH);
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Iterative restoring divider, one quotient bit per i_step.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   i_start                   load operands (takes magnitudes, remembers signs)
//   i_step                    perform one restoring step
//   i_dividend, i_divisor     operands (XLEN)
//   i_signed                  treat operands as two's complement
//   o_quotient_c, o_remainder_c  sign-corrected results (valid after 32 steps)
//   o_done_c                  high during the 32nd step
// Divide-by-zero and signed overflow are resolved by the caller.
module mdu_divider
  import rv32i_types::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_step,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  input  logic            i_signed,
  output logic [XLEN-1:0] o_quotient_c,
  output logic [XLEN-1:0] o_remainder_c,
  output logic            o_done_c
);

  localparam int unsigned CNT_W = 5;

  logic [XLEN-1:0]  r_quot;
  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_dvsr;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [CNT_W-1:0] r_cnt;

  logic            w_dvd_neg;
  logic            w_dvs_neg;
  logic [XLEN-1:0] w_dvd_mag;
  logic [XLEN-1:0] w_dvs_mag;
  logic [XLEN:0]   w_shift;
  logic [XLEN+1:0] w_diff;
  logic            w_fits;

  // Operand magnitudes; 0x80000000 maps onto itself, which is the correct magnitude.
  assign w_dvd_neg = i_signed & i_dividend[XLEN-1];
  assign w_dvs_neg = i_signed & i_divisor[XLEN-1];
  assign w_dvd_mag = w_dvd_neg ? -i_dividend : i_dividend;
  assign w_dvs_mag = w_dvs_neg ? -i_divisor  : i_divisor;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  assign w_shift = {r_rem, r_quot[XLEN-1]};
  assign w_diff  = {1'b0, w_shift} - {2'b00, r_dvsr};
  assign w_fits  = ~w_diff[XLEN+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_quot  <= '0;
      r_rem   <= '0;
      r_dvsr  <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_cnt   <= '0;
    end else if (i_start) begin
      r_quot  <= w_dvd_mag;
      r_rem   <= '0;
      r_dvsr  <= w_dvs_mag;
      r_neg_q <= w_dvd_neg ^ w_dvs_neg;
      r_neg_r <= w_dvd_neg;
      r_cnt   <= '0;
    end else if (i_step) begin
      r_rem   <= w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
      r_quot  <= {r_quot[XLEN-2:0], w_fits};
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  // Remainder takes the dividend's sign.
  assign o_quotient_c  = r_neg_q ? -r_quot : r_quot;
  assign o_remainder_c = r_neg_r ? -r_rem  : r_rem;
  assign o_done_c      = i_step && (r_cnt == CNT_W'(XLEN - 1));

endmodule

// File: rtl/mul_div_unit.sv
// RV32M multiply/divide execution unit with a single-entry CDB output.
// Optional build macro: MDU_FAST_MUL_EN -- multiplies use a single-stage
// multiplier (one CALC cycle) instead of the 32-step shift-add path.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   flush            abandon any in-flight op
//   issue_valid      reservation station presents an entry
//   issue_entry      operands, op, destination fields
//   mdu_ready        unit accepts an issue this cycle (combinational)
//   mul_valid        one-cycle CDB result pulse (combinational)
//   mul_data, mul_rd_addr, mul_rob_idx   result fields, zero unless mul_valid
module mul_div_unit
  import rv32i_types::*;
#(
  parameter int unsigned ROB_IDX_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     issue_valid,
  input  reservation_station_t     issue_entry,
  output logic                     mdu_ready,
  output logic                     mul_valid,
  output logic [XLEN-1:0]          mul_data,
  output logic [REG_ADDR_W-1:0]    mul_rd_addr,
  output logic [ROB_IDX_WIDTH-1:0] mul_rob_idx
);

  localparam int unsigned CNT_W  = 6;
  localparam int unsigned PROD_W = 2 * XLEN;

  mdu_state_t            r_state;
  mdu_state_t            w_next_state;
  logic [CNT_W-1:0]      r_cnt;
  multop_t               r_op;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [ROB_IDX_W-1:0]  r_rob;
  logic [XLEN-1:0]       r_mcand;
  logic [PROD_W-1:0]     r_prod;
  logic                  r_mul_neg;
  logic                  r_special;
  logic [XLEN-1:0]       r_special_val;

  logic              w_accept;
  logic              w_is_div_in;
  logic              w_div_zero;
  logic              w_div_ovf;
  logic              w_special_in;
  logic [XLEN-1:0]   w_special_val;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_cur_div;
  logic              w_calc_last;
  logic [XLEN:0]     w_sum;
  logic [PROD_W-1:0] w_prod_signed;
  logic [XLEN-1:0]   w_mul_res;
  logic [XLEN-1:0]   w_div_res;
  logic [XLEN-1:0]   w_result;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic              w_div_done_c;
  logic              w_unused_regf_we;

  // Write-enable only matters to the ROB; the unit completes the op either way.
  assign w_unused_regf_we = issue_entry.regf_we;

  assign mdu_ready = (r_state == IDLE) && !flush;
  assign w_accept  = issue_valid && mdu_ready;

  // Divide special cases resolved at issue, bypassing CALC.
  assign w_is_div_in  = op_is_div(issue_entry.multop);
  assign w_div_zero   = (issue_entry.rs2_data == '0);
  assign w_div_ovf    = op_div_signed(issue_entry.multop) &&
                        (issue_entry.rs1_data == 32'h8000_0000) &&
                        (issue_entry.rs2_data == 32'hFFFF_FFFF);
  assign w_special_in = w_is_div_in && (w_div_zero || w_div_ovf);

  always_comb begin
    w_special_val = '0;
    if (w_div_zero) begin
      w_special_val = op_is_rem(issue_entry.multop) ? issue_entry.rs1_data : 32'hFFFF_FFFF;
    end else begin
      w_special_val = op_is_rem(issue_entry.multop) ? 32'h0000_0000 : 32'h8000_0000;
    end
  end

  // Multiply on magnitudes of the 33-bit extended operands; sign restored at the end.
  assign w_a_neg = op_mul_a_signed(issue_entry.multop) & issue_entry.rs1_data[XLEN-1];
  assign w_b_neg = op_mul_b_signed(issue_entry.multop) & issue_entry.rs2_data[XLEN-1];
  assign w_a_mag = w_a_neg ? -issue_entry.rs1_data : issue_entry.rs1_data;
  assign w_b_mag = w_b_neg ? -issue_entry.rs2_data : issue_entry.rs2_data;

  assign w_cur_div = op_is_div(r_op);

  // Shift-add step: conditionally add multiplicand to the upper half, shift right.
  assign w_sum = {1'b0, r_prod[PROD_W-1:XLEN]} + (r_prod[0] ? {1'b0, r_mcand} : '0);

`ifdef MDU_FAST_MUL_EN
  assign w_calc_last = w_cur_div ? w_div_done_c : 1'b1;
`else
  assign w_calc_last = w_cur_div ? w_div_done_c : (r_cnt == CNT_W'(XLEN - 1));
`endif

  mdu_divider u_divider (
    .clk           (clk),
    .rst           (rst),
    .i_start       (w_accept && w_is_div_in),
    .i_step        ((r_state == CALC) && w_cur_div),
    .i_dividend    (issue_entry.rs1_data),
    .i_divisor     (issue_entry.rs2_data),
    .i_signed      (op_div_signed(issue_entry.multop)),
    .o_quotient_c  (w_quot),
    .o_remainder_c (w_rem),
    .o_done_c      (w_div_done_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; flush overrides everything but reset.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = w_special_in ? DONE : CALC;
      CALC:    if (w_calc_last) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
    if (flush) w_next_state = IDLE;
  end

  // Operand latch and multiplier datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_op          <= MOP_MUL;
      r_rd          <= '0;
      r_rob         <= '0;
      r_mcand       <= '0;
      r_prod        <= '0;
      r_mul_neg     <= 1'b0;
      r_special     <= 1'b0;
      r_special_val <= '0;
    end else if (w_accept) begin
      r_cnt         <= '0;
      r_op          <= issue_entry.multop;
      r_rd          <= issue_entry.rd_addr;
      r_rob         <= issue_entry.rd_rob_idx;
      r_mcand       <= w_a_mag;
      r_prod        <= {{XLEN{1'b0}}, w_b_mag};
      r_mul_neg     <= w_a_neg ^ w_b_neg;
      r_special     <= w_special_in;
      r_special_val <= w_special_val;
    end else if (r_state == CALC) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (!w_cur_div) begin
`ifdef MDU_FAST_MUL_EN
        r_prod <= PROD_W'(r_mcand) * PROD_W'(r_prod[XLEN-1:0]);
`else
        r_prod <= {w_sum, r_prod[XLEN-1:1]};
`endif
      end
    end
  end

  // Result selection
  assign w_prod_signed = r_mul_neg ? -r_prod : r_prod;
  assign w_mul_res     = (r_op == MOP_MUL) ? w_prod_signed[XLEN-1:0] : w_prod_signed[PROD_W-1:XLEN];
  assign w_div_res     = op_is_rem(r_op) ? w_rem : w_quot;
  assign w_result      = r_special ? r_special_val : (w_cur_div ? w_div_res : w_mul_res);

  // CDB outputs, forced to zero outside the valid pulse.
  assign mul_valid   = (r_state == DONE) && !flush;
  assign mul_data    = mul_valid ? w_result : '0;
  assign mul_rd_addr = mul_valid ? r_rd : '0;
  assign mul_rob_idx = mul_valid ? ROB_IDX_WIDTH'(r_rob) : '0;

endmodule
